// File: rtl/pulse_issue_queue_pkg.sv
// Shared definitions for event feeders in front of the pulse synchronizer.
// Holds the issue-FSM state encoding and the saturation limit helper.
package pulse_issue_queue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAPW  = 3'd4
    } piq_state_e;

    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_issue_queue_cnt.sv
// Saturating up/down counter with sync clear and sticky overflow; 1-cycle update.
// No backpressure: an increment at saturation is dropped and flagged.
module sat_updown_cnt
    import pulse_issue_queue_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Simultaneous inc and dec cancel, so saturation never flags overflow then.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pulse_issue_queue.sv
// Queues event strobes and replays them as 1-cycle sig pulses; sig is 2 cycles after the first ev.
// Waits on downstream busy (plus GAP idle cycles) between issues; events keep accumulating meanwhile.
module pulse_issue_queue
    import pulse_issue_queue_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev,
    input  logic             en,
    input  logic             clr,
    input  logic             busy,
    output logic             sig,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             idle
);

    localparam bit         HAS_GAP  = (GAP > 0);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    piq_state_e state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic       sig_q;

    sat_updown_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (ev),
        .dec_i (state_q == ST_ISSUE),
        .clr_i (clr),
        .cnt_o (pending),
        .ovf_o (overflow)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (en && (pending != '0) && !busy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_ARM;
            // busy is still rising here, so it is not looked at until WAIT.
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (!busy) begin
                    state_d = HAS_GAP ? ST_GAPW : ST_IDLE;
                end
            end
            ST_GAPW: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            sig_q   <= (state_d == ST_ISSUE);
        end
    end

    assign sig  = sig_q;
    assign idle = (state_q == ST_IDLE) && (pending == '0);

endmodule
